// File: rtl/seq_parser_multi.sv
// Framed packet parser: assembles length/stream/sequence packets into a wide output slot,
// tracking per-stream sequence numbers for gap, stale and framing errors.
module seq_parser_multi #(
    parameter int unsigned NUM_STREAMS = 32,
    parameter int unsigned MAX_WORDS   = 10,
    parameter int unsigned SEQ_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic [31:0]             dataIn,
    input  logic                    dataIn_val,
    output logic                    dataIn_ready,
    input  logic                    dataIN_last,
    output logic [MAX_WORDS*32-1:0] dataOut,
    output logic [15:0]             dataOut_bytes,
    output logic [15:0]             dataOut_stream,
    output logic [SEQ_W-1:0]        dataOut_seq,
    output logic                    dataOut_val,
    input  logic                    dataOut_ready,
    output logic                    packetLost,
    output logic [15:0]             lostCount,
    output logic                    stale,
    output logic                    lenError,
    output logic [7:0]              droppedCount
);

    localparam int unsigned IDX_W     = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int unsigned WI_W      = $clog2(MAX_WORDS + 1);
    localparam int unsigned MAX_BYTES = MAX_WORDS * 4;
    localparam int unsigned OUT_W     = MAX_WORDS * 32;

    typedef enum logic [1:0] {IDLE, HDR2, DATA, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       stream_q, stream_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [15:0]       rem_q, rem_d;
    logic [WI_W-1:0]   widx_q, widx_d;
    logic              lerr_q, lerr_d;
    logic [31:0]       buf_q [MAX_WORDS];
    logic [31:0]       buf_d [MAX_WORDS];

    logic [OUT_W-1:0]  dout_q, dout_d;
    logic [15:0]       bytes_q, bytes_d;
    logic [15:0]       ostream_q, ostream_d;
    logic [SEQ_W-1:0]  oseq_q, oseq_d;
    logic              oval_q, oval_d;
    logic              lost_q, lost_d;
    logic [15:0]       lcnt_q, lcnt_d;
    logic              stale_q, stale_d;
    logic              olerr_q, olerr_d;
    logic [7:0]        drop_q, drop_d;

    logic [SEQ_W-1:0]       tbl_seq_q [NUM_STREAMS];
    logic [SEQ_W-1:0]       tbl_seq_d [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] tbl_vld_q, tbl_vld_d;

    logic              accept_c;
    logic              commit_ok_c;
    logic [IDX_W-1:0]  tidx_c;
    logic [SEQ_W-1:0]  dist_c;
    logic [31:0]       dist32_c;
    logic              is_stale_c;
    logic [15:0]       pl_bytes_c;
    logic [31:0]       word_c;
    logic [15:0]       rem_n_c;
    logic              word_err_c;

    assign dataIn_ready   = (state_q != COMMIT);
    assign dataOut        = dout_q;
    assign dataOut_bytes  = bytes_q;
    assign dataOut_stream = ostream_q;
    assign dataOut_seq    = oseq_q;
    assign dataOut_val    = oval_q;
    assign packetLost     = lost_q;
    assign lostCount      = lcnt_q;
    assign stale          = stale_q;
    assign lenError       = olerr_q;
    assign droppedCount   = drop_q;

    assign accept_c    = dataIn_val && (state_q != COMMIT);
    assign commit_ok_c = !oval_q || dataOut_ready;
    assign tidx_c      = stream_q[IDX_W-1:0];
    assign dist_c      = seq_q - tbl_seq_q[tidx_c] - SEQ_W'(1);
    assign dist32_c    = 32'(dist_c);
    assign is_stale_c  = tbl_vld_q[tidx_c] && dist_c[SEQ_W-1];

    // Payload byte count reported with the packet, clipped to the slot size
    always_comb begin
        pl_bytes_c = (len_q < 16'd8) ? 16'd0 : (len_q - 16'd8);
        if (pl_bytes_c > 16'(MAX_BYTES)) begin
            pl_bytes_c = 16'(MAX_BYTES);
        end
    end

    // Trim the incoming payload word against the remaining byte budget
    always_comb begin
        word_c     = dataIn;
        rem_n_c    = rem_q;
        word_err_c = 1'b0;
        if (rem_q >= 16'd4) begin
            rem_n_c = rem_q - 16'd4;
        end else if (rem_q != 16'd0) begin
            word_c  = dataIn & ~(32'hFFFF_FFFF >> {rem_q[1:0], 3'b000});
            rem_n_c = 16'd0;
        end else begin
            word_c     = 32'd0;
            word_err_c = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        stream_d  = stream_q;
        seq_d     = seq_q;
        rem_d     = rem_q;
        widx_d    = widx_q;
        lerr_d    = lerr_q;
        buf_d     = buf_q;
        dout_d    = dout_q;
        bytes_d   = bytes_q;
        ostream_d = ostream_q;
        oseq_d    = oseq_q;
        oval_d    = oval_q;
        lost_d    = lost_q;
        lcnt_d    = lcnt_q;
        stale_d   = stale_q;
        olerr_d   = olerr_q;
        drop_d    = drop_q;
        tbl_seq_d = tbl_seq_q;
        tbl_vld_d = tbl_vld_q;

        if (oval_q && dataOut_ready) begin
            oval_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (dataIN_last) begin
                        drop_d = (drop_q == 8'hFF) ? drop_q : (drop_q + 8'd1);
                    end else begin
                        len_d    = dataIn[31:16];
                        stream_d = dataIn[15:0];
                        if (dataIn[31:16] < 16'd8) begin
                            rem_d  = 16'd0;
                            lerr_d = 1'b1;
                        end else begin
                            rem_d  = dataIn[31:16] - 16'd8;
                            lerr_d = 1'b0;
                        end
                        state_d = HDR2;
                    end
                end
            end
            HDR2: begin
                if (accept_c) begin
                    if (dataIN_last) begin
                        drop_d  = (drop_q == 8'hFF) ? drop_q : (drop_q + 8'd1);
                        state_d = IDLE;
                    end else begin
                        seq_d  = dataIn[SEQ_W-1:0];
                        widx_d = '0;
                        for (int i = 0; i < int'(MAX_WORDS); i++) begin
                            buf_d[i] = 32'd0;
                        end
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept_c) begin
                    rem_d = rem_n_c;
                    if (word_err_c) begin
                        lerr_d = 1'b1;
                    end
                    // Words beyond the slot are dropped but still flag the packet
                    if (widx_q < WI_W'(MAX_WORDS)) begin
                        for (int i = 0; i < int'(MAX_WORDS); i++) begin
                            if (WI_W'(i) == widx_q) begin
                                buf_d[i] = word_c;
                            end
                        end
                        widx_d = widx_q + WI_W'(1);
                    end else begin
                        lerr_d = 1'b1;
                    end
                    if (dataIN_last) begin
                        if (rem_n_c != 16'd0) begin
                            lerr_d = 1'b1;
                        end
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (commit_ok_c) begin
                    for (int i = 0; i < int'(MAX_WORDS); i++) begin
                        dout_d[(int'(MAX_WORDS) - i) * 32 - 1 -: 32] = buf_q[i];
                    end
                    bytes_d   = pl_bytes_c;
                    ostream_d = stream_q;
                    oseq_d    = seq_q;
                    olerr_d   = lerr_q;
                    oval_d    = 1'b1;
                    lost_d    = 1'b0;
                    lcnt_d    = 16'd0;
                    stale_d   = 1'b0;
                    if (tbl_vld_q[tidx_c]) begin
                        if (dist_c[SEQ_W-1]) begin
                            stale_d = 1'b1;
                        end else if (dist_c != '0) begin
                            lost_d = 1'b1;
                            lcnt_d = (dist32_c > 32'd65535) ? 16'hFFFF : dist32_c[15:0];
                        end
                    end
                    // Stale or malformed packets leave the stream's history untouched
                    if (!lerr_q && !is_stale_c) begin
                        tbl_seq_d[tidx_c] = seq_q;
                        tbl_vld_d[tidx_c] = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            len_q     <= 16'd0;
            stream_q  <= 16'd0;
            seq_q     <= '0;
            rem_q     <= 16'd0;
            widx_q    <= '0;
            lerr_q    <= 1'b0;
            dout_q    <= '0;
            bytes_q   <= 16'd0;
            ostream_q <= 16'd0;
            oseq_q    <= '0;
            oval_q    <= 1'b0;
            lost_q    <= 1'b0;
            lcnt_q    <= 16'd0;
            stale_q   <= 1'b0;
            olerr_q   <= 1'b0;
            drop_q    <= 8'd0;
            tbl_vld_q <= '0;
            for (int i = 0; i < int'(MAX_WORDS); i++) begin
                buf_q[i] <= 32'd0;
            end
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                tbl_seq_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            stream_q  <= stream_d;
            seq_q     <= seq_d;
            rem_q     <= rem_d;
            widx_q    <= widx_d;
            lerr_q    <= lerr_d;
            dout_q    <= dout_d;
            bytes_q   <= bytes_d;
            ostream_q <= ostream_d;
            oseq_q    <= oseq_d;
            oval_q    <= oval_d;
            lost_q    <= lost_d;
            lcnt_q    <= lcnt_d;
            stale_q   <= stale_d;
            olerr_q   <= olerr_d;
            drop_q    <= drop_d;
            tbl_vld_q <= tbl_vld_d;
            for (int i = 0; i < int'(MAX_WORDS); i++) begin
                buf_q[i] <= buf_d[i];
            end
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                tbl_seq_q[i] <= tbl_seq_d[i];
            end
        end
    end

endmodule
